// File: rtl/drain_scheduler_if.sv
// Handshake and write-port bundle between the drain scheduler and its
// environment (tile start, buffer backpressure, mux/serializer controls).
interface drain_scheduler_if #(
  parameter int CHANNEL_N = 2,
  parameter int ADDR_W    = 10
);
  logic                         mac_output_valid;
  logic [ADDR_W-1:0]            base_addr;
  logic [ADDR_W-1:0]            row_stride;
  logic                         out_ready;
  logic [$clog2(CHANNEL_N)-1:0] mux_sel;
  logic [CHANNEL_N-1:0]         ser_shift;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic                         busy;
  logic                         done;
  logic                         overrun;

  modport master (
    output mac_output_valid, base_addr, row_stride, out_ready,
    input  mux_sel, ser_shift, wr_en, wr_addr, busy, done, overrun
  );

  modport slave (
    input  mac_output_valid, base_addr, row_stride, out_ready,
    output mux_sel, ser_shift, wr_en, wr_addr, busy, done, overrun
  );
endinterface

// File: rtl/drain_scheduler.sv
// Drains the per-channel output serializers into the output buffer after
// each MAC tile, one row beat per accepted cycle.
//
// state | meaning
// IDLE  | waiting for a loaded tile
// XFER  | shifting beats out, channel by channel, row by row
// DONE  | one-cycle end-of-tile marker; accepts a back-to-back start
module drain_scheduler #(
  parameter int CHANNEL_N = 2,
  parameter int POX       = 3,
  parameter int POY       = 3,
  parameter int ADDR_W    = 10
) (
  input logic               clk,
  input logic               rst,
  drain_scheduler_if.slave  bus
);
  localparam int CW = (CHANNEL_N > 1) ? $clog2(CHANNEL_N) : 1;
  localparam int RW = (POY > 1) ? $clog2(POY) : 1;
  localparam logic [CW-1:0] CHAN_LAST = CW'(CHANNEL_N - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(POY - 1);

  if (CHANNEL_N < 2 || POY < 1 || POX < 1) begin : g_param_check
    $error("drain_scheduler: CHANNEL_N must be >= 2, POY and POX >= 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     chan_cnt_q, chan_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]     mux_sel_q, mux_sel_d;
  logic              wr_en_q, wr_en_d;
  logic              overrun_q, overrun_d;
  logic              beat;

  // A reset cycle must not shift a serializer, even though state is still XFER.
  assign beat = (state_q == XFER) && bus.out_ready && !rst;

  always_comb begin
    state_d    = state_q;
    chan_cnt_d = chan_cnt_q;
    row_cnt_d  = row_cnt_q;
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    wr_addr_d  = wr_addr_q;
    mux_sel_d  = mux_sel_q;
    wr_en_d    = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.mac_output_valid) begin
          state_d    = XFER;
          cur_addr_d = bus.base_addr;
          stride_d   = bus.row_stride;
          chan_cnt_d = '0;
          row_cnt_d  = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      XFER: begin
        mux_sel_d = chan_cnt_q;
        if (bus.mac_output_valid) overrun_d = 1'b1;
        if (beat) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = cur_addr_q;
          cur_addr_d = cur_addr_q + stride_q;
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            if (chan_cnt_q == CHAN_LAST) begin
              chan_cnt_d = '0;
              state_d    = DONE;
            end else begin
              chan_cnt_d = chan_cnt_q + CW'(1);
            end
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      chan_cnt_q <= '0;
      row_cnt_q  <= '0;
      cur_addr_q <= '0;
      stride_q   <= '0;
      wr_addr_q  <= '0;
      mux_sel_q  <= '0;
      wr_en_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_cnt_q <= chan_cnt_d;
      row_cnt_q  <= row_cnt_d;
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      wr_addr_q  <= wr_addr_d;
      mux_sel_q  <= mux_sel_d;
      wr_en_q    <= wr_en_d;
      overrun_q  <= overrun_d;
    end
  end

  // mux_sel follows the channel live in XFER and holds its last value elsewhere.
  assign bus.mux_sel   = mux_sel_d;
  assign bus.ser_shift = beat ? (CHANNEL_N'(1) << chan_cnt_q) : '0;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_drain_scheduler.sv
// Directed bench for drain_scheduler: expected write addresses and shift
// patterns are queued per started tile and retired as the DUT produces them.
module tb_drain_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drain_scheduler_if #(.CHANNEL_N(2), .ADDR_W(10)) bus ();
  drain_scheduler #(.CHANNEL_N(2), .POX(3), .POY(3), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_addr[$];
  logic [1:0] exp_shift[$];

  logic [9:0] base_v;
  logic [9:0] stride_v;
  logic       rst_v;
  int         cyc, n_wr, done_cyc, first_wr, busy_cnt;
  logic       wr_hist [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tile(input logic [9:0] base, input logic [9:0] stride);
    logic [9:0] a;
    logic [1:0] one;
    one = 2'b01;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 3; r++) begin
        a = base + 10'((c * 3 + r)) * stride;
        exp_addr.push_back(a);
        exp_shift.push_back(one << c);
      end
    end
  endtask

  task automatic mark();
    cyc = 0; n_wr = 0; done_cyc = -1; first_wr = -1; busy_cnt = 0;
    for (int i = 0; i < 64; i++) wr_hist[i] = 1'b0;
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic tick(input logic v, input logic r, input logic push);
    bus.mac_output_valid = v;
    bus.out_ready        = r;
    bus.base_addr        = base_v;
    bus.row_stride       = stride_v;
    rst                  = rst_v;
    if (push) push_tile(base_v, stride_v);
    #4;
    if (!r) begin
      chk("no_shift_when_stalled", 32'(bus.ser_shift), 32'd0);
    end else if (bus.ser_shift != 2'b00) begin
      if (exp_shift.size() == 0) chk("shift_extra", 32'(bus.ser_shift), 32'd0);
      else begin
        chk("ser_shift", 32'(bus.ser_shift), 32'(exp_shift.pop_front()));
        chk("mux_sel", 32'(bus.mux_sel), 32'(bus.ser_shift == 2'b10));
      end
    end
    if (bus.wr_en === 1'b1) begin
      if (exp_addr.size() == 0) chk("wr_extra", 32'(bus.wr_en), 32'd0);
      else chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr.pop_front()));
      if (first_wr < 0) first_wr = cyc;
      n_wr++;
      if (cyc < 64) wr_hist[cyc] = 1'b1;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_mux_sel"}, 32'(bus.mux_sel), 32'd0);
    chk({tag, "_shift"},   32'(bus.ser_shift), 32'd0);
  endtask

  initial begin
    base_v = '0; stride_v = '0; rst_v = 1'b1;
    bus.mac_output_valid = 1'b0; bus.out_ready = 1'b0;
    bus.base_addr = '0; bus.row_stride = '0; rst = 1'b1;
    @(posedge clk); #1;
    mark();
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_v = 1'b0;
    tick(0, 1, 0);
    chk_all_zero("reset");

    // Basic drain
    base_v = 10'h010; stride_v = 10'd4;
    mark();
    tick(1, 1, 1);
    for (int i = 1; i <= 8; i++) tick(0, 1, 0);
    chk("basic_writes", 32'(n_wr), 32'd6);
    chk("basic_first_wr", 32'(first_wr), 32'd2);
    chk("basic_done_cyc", 32'(done_cyc), 32'd7);
    chk("basic_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("basic_last_addr", 32'(bus.wr_addr), 32'h024);

    // Backpressure on cycles 2-4
    base_v = 10'h020; stride_v = 10'd8;
    mark();
    tick(1, 1, 1);
    tick(0, 1, 0);
    for (int i = 2; i <= 4; i++) tick(0, 0, 0);
    for (int i = 5; i <= 12; i++) tick(0, 1, 0);
    chk("bp_writes", 32'(n_wr), 32'd6);
    chk("bp_no_wr_3", 32'(wr_hist[3]), 32'd0);
    chk("bp_no_wr_4", 32'(wr_hist[4]), 32'd0);
    chk("bp_no_wr_5", 32'(wr_hist[5]), 32'd0);
    chk("bp_done_cyc", 32'(done_cyc), 32'd10);

    // Back-to-back start in the DONE cycle
    base_v = 10'h040; stride_v = 10'd1;
    mark();
    tick(1, 1, 1);
    for (int i = 1; i <= 6; i++) tick(0, 1, 0);
    base_v = 10'h100; stride_v = 10'd4;
    tick(1, 1, 1);
    for (int i = 8; i <= 16; i++) tick(0, 1, 0);
    chk("b2b_writes", 32'(n_wr), 32'd12);
    chk("b2b_done_cyc", 32'(done_cyc), 32'd14);
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'd14);
    chk("b2b_overrun", 32'(bus.overrun), 32'd0);

    // Start pulse during XFER
    base_v = 10'h200; stride_v = 10'd8;
    mark();
    tick(1, 1, 1);
    tick(0, 1, 0);
    tick(1, 1, 0);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    for (int i = 3; i <= 12; i++) tick(0, 1, 0);
    chk("ovr_writes", 32'(n_wr), 32'd6);
    chk("ovr_done_cyc", 32'(done_cyc), 32'd7);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Reset after the third beat
    base_v = 10'h080; stride_v = 10'd1;
    mark();
    tick(1, 1, 1);
    for (int i = 1; i <= 3; i++) tick(0, 1, 0);
    rst_v = 1'b1;
    tick(0, 0, 0);
    rst_v = 1'b0;
    chk_all_zero("rst_mid");
    chk("rst_pending", 32'(exp_addr.size()), 32'd3);
    exp_addr.delete();
    exp_shift.delete();
    for (int i = 5; i <= 8; i++) tick(0, 1, 0);
    chk("rst_writes", 32'(n_wr), 32'd3);
    base_v = 10'h300; stride_v = 10'd1;
    mark();
    tick(1, 1, 1);
    for (int i = 1; i <= 8; i++) tick(0, 1, 0);
    chk("post_rst_writes", 32'(n_wr), 32'd6);
    chk("post_rst_done_cyc", 32'(done_cyc), 32'd7);

    // Address wrap
    base_v = 10'h3FC; stride_v = 10'd2;
    mark();
    tick(1, 1, 1);
    for (int i = 1; i <= 8; i++) tick(0, 1, 0);
    chk("wrap_writes", 32'(n_wr), 32'd6);
    chk("wrap_last_addr", 32'(bus.wr_addr), 32'h006);

    chk("sb_addr_empty", 32'(exp_addr.size()), 32'd0);
    chk("sb_shift_empty", 32'(exp_shift.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
